// File: rtl/arb_pkg.sv
`default_nettype none
// arb_pkg: shared state encoding, burst default and arbitration helper for tristate_bus_arbiter.
// Rev 1.0
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10,
    TURN = 2'b11
  } arb_state_t;

  localparam int BURST_MAX_DEFAULT = 4;

  // last_owner == 1 means requester 1 held the bus most recently, so 0 wins a tie.
  function automatic arb_state_t arbitrate(input logic r0, input logic r1, input logic last_owner);
    arb_state_t s;
    if (r0 && r1)  s = last_owner ? GNT0 : GNT1;
    else if (r0)   s = GNT0;
    else if (r1)   s = GNT1;
    else           s = IDLE;
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tri_bus_driver.sv
`default_nettype none
// tri_bus_driver: per-bit tristate buffers placing d0 or d1 on the shared bus under its grant.
// Rev 1.0
module tri_bus_driver #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic             gnt0,
  input  logic             gnt1,
  output tri   [WIDTH-1:0] bus
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    bufif1 u_drv0 (bus[i], d0[i], gnt0);
    bufif1 u_drv1 (bus[i], d1[i], gnt1);
  end

endmodule
`default_nettype wire

// File: rtl/tristate_bus_arbiter.sv
`default_nettype none
// tristate_bus_arbiter: two-requester tristate bus arbiter with burst limit and fair tie-break.
// Rev 1.0 -- define TRISTATE_BUS_ARBITER_TURNAROUND_EN to insert a one-cycle TURN on every hand-off.
module tristate_bus_arbiter
  import arb_pkg::*;
#(
  parameter int WIDTH     = 1,
  parameter int BURST_MAX = BURST_MAX_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             sel,
  output logic             oe,
  output tri   [WIDTH-1:0] bus,
  output logic             busy
);

  localparam logic [7:0] LIMIT = 8'(BURST_MAX - 1);

  arb_state_t state, state_nx;
  logic [7:0] cnt, cnt_nx;
  logic       last_owner, last_owner_nx;
  logic       at_limit;

  always_comb begin
    state_nx      = state;
    cnt_nx        = 8'd0;
    last_owner_nx = last_owner;
    at_limit      = (cnt == LIMIT);
    case (state)
      IDLE, TURN: state_nx = arbitrate(req0, req1, last_owner);
      GNT0: begin
        if (!req0 || (at_limit && req1)) begin
          last_owner_nx = 1'b0;
`ifdef TRISTATE_BUS_ARBITER_TURNAROUND_EN
          state_nx = TURN;
`else
          state_nx = req1 ? GNT1 : IDLE;
`endif
        end else begin
          // Burst limit with nobody waiting: keep the grant, start a new burst.
          cnt_nx = at_limit ? 8'd0 : cnt + 8'd1;
        end
      end
      GNT1: begin
        if (!req1 || (at_limit && req0)) begin
          last_owner_nx = 1'b1;
`ifdef TRISTATE_BUS_ARBITER_TURNAROUND_EN
          state_nx = TURN;
`else
          state_nx = req0 ? GNT0 : IDLE;
`endif
        end else begin
          cnt_nx = at_limit ? 8'd0 : cnt + 8'd1;
        end
      end
    endcase
  end

  // Grants are flopped from the next state so the bus enables come straight off flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      last_owner <= 1'b1;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      sel        <= 1'b0;
      oe         <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      last_owner <= last_owner_nx;
      gnt0       <= (state_nx == GNT0);
      gnt1       <= (state_nx == GNT1);
      sel        <= (state_nx == GNT1);
      oe         <= (state_nx == GNT0) || (state_nx == GNT1);
    end
  end

  assign busy = (state != IDLE);

  tri_bus_driver #(.WIDTH(WIDTH)) u_drv (
    .d0   (d0),
    .d1   (d1),
    .gnt0 (gnt0),
    .gnt1 (gnt1),
    .bus  (bus)
  );

endmodule
`default_nettype wire

// File: tb/tb_tristate_bus_arbiter.sv
`default_nettype none
// tb_tristate_bus_arbiter: vector table, directed corner sequences and randomized model comparison.
module tb_tristate_bus_arbiter;

  localparam int W    = 4;
  localparam int BMAX = 4;
`ifdef TRISTATE_BUS_ARBITER_TURNAROUND_EN
  localparam bit TA = 1'b1;
`else
  localparam bit TA = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0, req1;
  logic [W-1:0] d0, d1;
  logic         gnt0, gnt1, sel, oe, busy;
  tri   [W-1:0] bus;

  // A released bus reads as zero; tests of high-Z drive all-ones data.
  pulldown (bus);

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: current owner (-1 none), turnaround flag, last owner, cycles held.
  int m_owner, m_last, m_run;
  bit m_turn;

  typedef struct {
    logic         r0, r1;
    logic         g0, g1, s, o, b;
    logic [W-1:0] bus;
  } vec_t;

  tristate_bus_arbiter #(.WIDTH(W), .BURST_MAX(BMAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req0  (req0),
    .req1  (req1),
    .d0    (d0),
    .d1    (d1),
    .gnt0  (gnt0),
    .gnt1  (gnt1),
    .sel   (sel),
    .oe    (oe),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_turn = 1'b0; m_last = 1; m_run = 0;
  endtask

  task automatic model_step(input logic r0, input logic r1);
    if (m_owner < 0) begin
      m_turn = 1'b0;
      m_run  = 0;
      if (r0 && r1)  m_owner = (m_last == 1) ? 0 : 1;
      else if (r0)   m_owner = 0;
      else if (r1)   m_owner = 1;
      else           m_owner = -1;
    end else begin
      bit mine, other, limit;
      mine  = (m_owner == 0) ? r0 : r1;
      other = (m_owner == 0) ? r1 : r0;
      limit = (m_run % BMAX) == (BMAX - 1);
      if (!mine || (limit && other)) begin
        m_last = m_owner;
        m_run  = 0;
        if (TA) begin
          m_turn  = 1'b1;
          m_owner = -1;
        end else begin
          m_owner = other ? 1 - m_owner : -1;
        end
      end else begin
        m_run++;
      end
    end
  endtask

  task automatic model_check(input string tag);
    logic [W-1:0] eb;
    eb = (m_owner == 0) ? d0 : (m_owner == 1) ? d1 : '0;
    check({tag, ".gnt0"}, gnt0, m_owner == 0);
    check({tag, ".gnt1"}, gnt1, m_owner == 1);
    check({tag, ".sel"},  sel,  m_owner == 1);
    check({tag, ".oe"},   oe,   m_owner >= 0);
    check({tag, ".busy"}, busy, (m_owner >= 0) || m_turn);
    check({tag, ".bus"},  bus,  eb);
  endtask

  task automatic cycle(input logic r0, input logic r1, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    req0 = r0; req1 = r1; d0 = a; d1 = b;
    @(posedge clk);
    model_step(r0, r1);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[10];
    logic eg0, eg1;
    int   w0, w1;

    tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'hA};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, TA,   4'h0};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'h5};
    tbl[4] = '{1'b1, 1'b0, !TA,  1'b0, 1'b0, !TA,  1'b1, TA ? 4'h0 : 4'hA};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'hA};
    tbl[6] = '{1'b0, 1'b1, 1'b0, !TA,  !TA,  !TA,  1'b1, TA ? 4'h0 : 4'h5};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'h5};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, TA,   4'h0};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0};

    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; d0 = '0; d1 = '0;
    #3;
    req0 = 1'b1; d0 = '1; d1 = '1;
    #1;
    check("rst.gnt0", gnt0, 0);
    check("rst.gnt1", gnt1, 0);
    check("rst.sel",  sel,  0);
    check("rst.oe",   oe,   0);
    check("rst.busy", busy, 0);
    check("rst.bus",  bus,  0);
    @(posedge clk); #1;
    check("rst_edge.gnt0", gnt0, 0);
    check("rst_edge.bus",  bus,  0);
    @(negedge clk);
    rst_n = 1'b1; req0 = 1'b0;
    model_reset();

    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].r0, tbl[i].r1, 4'hA, 4'h5);
      check($sformatf("vec%0d.gnt0", i), gnt0, tbl[i].g0);
      check($sformatf("vec%0d.gnt1", i), gnt1, tbl[i].g1);
      check($sformatf("vec%0d.sel",  i), sel,  tbl[i].s);
      check($sformatf("vec%0d.oe",   i), oe,   tbl[i].o);
      check($sformatf("vec%0d.busy", i), busy, tbl[i].b);
      check($sformatf("vec%0d.bus",  i), bus,  tbl[i].bus);
    end

    apply_reset();
    for (int k = 1; k <= 9; k++) begin
      cycle(1'b1, 1'b1, 4'h3, 4'hC);
      eg0 = TA ? (k <= 4) : (k <= 4 || k == 9);
      eg1 = TA ? (k >= 6) : (k >= 5 && k <= 8);
      check($sformatf("burst%0d.gnt0", k), gnt0, eg0);
      check($sformatf("burst%0d.gnt1", k), gnt1, eg1);
      check($sformatf("burst%0d.busy", k), busy, 1);
      check($sformatf("burst%0d.bus",  k), bus,  eg0 ? 4'h3 : eg1 ? 4'hC : 4'h0);
    end

    apply_reset();
    for (int k = 1; k <= 10; k++) begin
      cycle(1'b0, 1'b1, 4'h0, 4'hF);
      check($sformatf("hold%0d.gnt1", k), gnt1, 1);
      check($sformatf("hold%0d.sel",  k), sel,  1);
      check($sformatf("hold%0d.bus",  k), bus,  4'hF);
    end

    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst.gnt1", gnt1, 0);
    check("async_rst.oe",   oe,   0);
    check("async_rst.busy", busy, 0);
    check("async_rst.bus",  bus,  0);
    @(negedge clk);
    req1 = 1'b0; rst_n = 1'b1;
    model_reset();

    w0 = 0; w1 = 0;
    for (int c = 0; c < 1000; c++) begin
      cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7, W'($urandom), W'($urandom));
      model_check("rnd");
      check("rnd.excl", gnt0 & gnt1, 0);
      w0 = (req0 && !gnt0) ? w0 + 1 : 0;
      w1 = (req1 && !gnt1) ? w1 + 1 : 0;
      check("rnd.starve0", w0 > BMAX + 1, 0);
      check("rnd.starve1", w1 > BMAX + 1, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tristate_bus_arbiter.md
TRISTATE_BUS_ARBITER -- requirements
Module: tristate_bus_arbiter

Interface
REQ-001 The block SHALL have one clock, clk, and one asynchronous, active-low reset, rst_n.
REQ-002 The block SHALL have parameter WIDTH, default 1, the bus and data width in bits.
REQ-003 The block SHALL have parameter BURST_MAX, default 4, the maximum consecutive grant cycles while the other requester waits; legal range 1..255.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req0, req1  input  1  requester 0/1 bus request, level-sensitive.
REQ-007 d0, d1  input  WIDTH  requester 0/1 data to drive onto the bus.
REQ-008 gnt0, gnt1  output  1  registered grant to requester 0/1.
REQ-009 sel  output  1  registered mux select: 1 while requester 1 owns the bus, else 0.
REQ-010 oe  output  1  registered bus enable, equal to gnt0 | gnt1.
REQ-011 bus  output (tri)  WIDTH  d0 when gnt0, d1 when gnt1, high-Z otherwise.
REQ-012 busy  output  1  high whenever the state is not IDLE.

Function
REQ-013 The block SHALL implement states IDLE, GNT0, GNT1 and TURN, with all state changes on the rising edge of clk.
REQ-014 From IDLE: req0 only -> GNT0; req1 only -> GNT1; both -> the requester that is not last_owner; neither -> stay in IDLE.
REQ-015 The grant latency SHALL be one cycle: a request sampled at edge N gives a grant visible after edge N.
REQ-016 In GNTx, an 8-bit burst counter SHALL increment each cycle, starting at 0 on entry.
REQ-017 GNTx SHALL be left when reqx is low.
REQ-018 GNTx SHALL also be left when the counter equals BURST_MAX-1 and the other requester is high.
REQ-019 If the counter reaches BURST_MAX-1 while the other requester is low, the owner SHALL keep the grant and the counter SHALL reload to 0.
REQ-020 On leaving GNTx, last_owner SHALL be set to x.
REQ-021 gnt0 and gnt1 SHALL never be high in the same cycle, and the bus SHALL never have two drivers.
REQ-022 The TURN state SHALL last exactly one cycle with all grants low, oe low and the bus high-Z.
REQ-023 After TURN, the next state SHALL follow the IDLE arbitration rules of REQ-014.
REQ-024 If reqx drops and rises again in the same cycle as the hand-off decision, the other requester SHALL take priority.

Reset
REQ-025 While rst_n is low, the outputs SHALL be gnt0=0, gnt1=0, sel=0, oe=0, busy=0 and bus high-Z, immediately and without waiting for clk.
REQ-026 While rst_n is low, the state SHALL be IDLE, the counter 0 and last_owner 1, so that requester 0 wins the first contention.
REQ-027 A reset asserted mid-grant SHALL release the bus within the same cycle, asynchronously.
REQ-028 After reset is released, the first state change SHALL occur on the first rising clk edge with rst_n high.

Configuration
REQ-029 The block SHALL support macro TRISTATE_BUS_ARBITER_TURNAROUND_EN.
REQ-030 With TRISTATE_BUS_ARBITER_TURNAROUND_EN defined, every exit from GNT0 or GNT1 SHALL pass through TURN.
REQ-031 Without TRISTATE_BUS_ARBITER_TURNAROUND_EN, exits SHALL go directly to the other GNT state when the other requester is high, or to IDLE otherwise, and TURN SHALL be unreachable.

Structure
REQ-032 A shared package arb_pkg SHALL hold the state encoding constants (IDLE=2'b00, GNT0=2'b01, GNT1=2'b10, TURN=2'b11) and the default BURST_MAX value.
REQ-033 The bus drive SHALL be built in one sub-module, tri_bus_driver (ports d0, d1, gnt0, gnt1, bus), using bufif-style primitives.
REQ-034 The state machine, counter and last_owner SHALL reside in tristate_bus_arbiter.

Verification
REQ-035 Reset then req0=1, d0=1 -> gnt0=1, sel=0, oe=1 and bus=1 one cycle later; bus high-Z during reset.
REQ-036 req0=req1=1 from IDLE after reset -> gnt0 first; BURST_MAX=4 -> gnt0 held 4 cycles, then gnt1 (with TURN, one idle high-Z cycle between them).
REQ-037 req1 only, held for 10 cycles -> gnt1 held continuously for all 10 cycles, with no hand-off at the burst limit.
REQ-038 rst_n pulled low mid-GNT1 between clock edges -> gnt1=0, oe=0 and bus high-Z before the next edge.
REQ-039 Random req0/req1 for 1000 cycles -> gnt0 & gnt1 never 1 together, and no waiting requester is starved beyond BURST_MAX+1 cycles.
REQ-040 Build without the macro, both requesting -> gnt0 falls and gnt1 rises on the same edge, and busy stays 1.
